// File: rtl/javk_memio.sv
// javk_memio: memory/peripheral responder for the JAVK CPU bus.
//
// One bus access is presented every clock cycle on addrbus/rw/databus.
// The responder serves a RAM window and a three-register I/O page that
// fronts two console FIFOs (CPU->host TX, host->CPU RX).
//
// Ports
//   clk       rising-edge clock for all state
//   rst       asynchronous, active-high reset
//   databus   8-bit CPU data bus; driven on mapped reads only, else high-Z
//   addrbus   16-bit CPU address
//   rw        1 = CPU read, 0 = CPU write
//   tx_data   head byte of the TX FIFO (8'h00 while empty)
//   tx_valid  TX FIFO holds at least one byte
//   tx_ready  host takes tx_data on this edge
//   rx_data   byte offered by the host
//   rx_valid  host offers rx_data
//   rx_ready  RX FIFO has room
//
// I/O page: +0 TXDATA (write pushes), +1 RXDATA (read pops),
//           +2 STATUS {2'b0, rx_unf, tx_ovf, rx_full, rx_empty, tx_empty, tx_full}

module javk_memio #(
    parameter logic [15:0] RAM_BASE = 16'h0000,
    parameter int          RAM_AW   = 8,
    parameter logic [15:0] IO_BASE  = 16'hFF00,
    parameter int          FIFO_AW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [7:0]  databus,
    input  logic [15:0] addrbus,
    input  logic        rw,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam int                 RAM_SIZE = 1 << RAM_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1'b1);
    localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(1'b0);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1'b1);
    localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW + 1)'(1'b0);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]        IO_TX    = IO_BASE;
    localparam logic [15:0]        IO_RX    = IO_BASE + 16'd1;
    localparam logic [15:0]        IO_ST    = IO_BASE + 16'd2;

    // Occupancy after one edge; push and pop together leave it unchanged.
    function automatic logic [FIFO_AW:0] cnt_next(input logic [FIFO_AW:0] cnt,
                                                  input logic push,
                                                  input logic pop);
        logic [FIFO_AW:0] n;
        case ({push, pop})
            2'b10:   n = cnt + CNT_ONE;
            2'b01:   n = cnt - CNT_ONE;
            default: n = cnt;
        endcase
        return n;
    endfunction

    // Storage (not reset: RAM survives reset, FIFO slots are don't-care when empty)
    logic [7:0]         ram_mem_r [0:RAM_SIZE-1];
    logic [7:0]         tx_mem_r  [0:DEPTH-1];
    logic [7:0]         rx_mem_r  [0:DEPTH-1];

    logic [FIFO_AW-1:0] tx_wptr_r, tx_rptr_r;
    logic [FIFO_AW:0]   tx_cnt_r;
    logic [FIFO_AW-1:0] rx_wptr_r, rx_rptr_r;
    logic [FIFO_AW:0]   rx_cnt_r;
    logic               tx_ovf_r, rx_unf_r;

    logic               ram_hit_s, io_tx_s, io_rx_s, io_st_s, io_hit_s;
    logic               wr_s, rd_s;
    logic               tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic               tx_push_s, tx_pop_s, tx_ovf_set_s, tx_ovf_clr_s;
    logic               rx_push_s, rx_pop_s, rx_unf_set_s, rx_unf_clr_s;
    logic               ram_we_s, drive_s;
    logic [7:0]         status_s, rdata_s;

    // Address decode; RAM takes precedence should the windows ever overlap.
    assign ram_hit_s = (addrbus[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
    assign io_tx_s   = !ram_hit_s && (addrbus == IO_TX);
    assign io_rx_s   = !ram_hit_s && (addrbus == IO_RX);
    assign io_st_s   = !ram_hit_s && (addrbus == IO_ST);
    assign io_hit_s  = io_tx_s || io_rx_s || io_st_s;
    assign wr_s      = !rw;
    assign rd_s      = rw;

    assign tx_full_s  = (tx_cnt_r == CNT_FULL);
    assign tx_empty_s = (tx_cnt_r == CNT_ZERO);
    assign rx_full_s  = (rx_cnt_r == CNT_FULL);
    assign rx_empty_s = (rx_cnt_r == CNT_ZERO);

    // All FIFO decisions use pre-edge occupancy, so a pop never makes room
    // for a push on the same edge.
    assign tx_push_s    = wr_s && io_tx_s && !tx_full_s;
    assign tx_ovf_set_s = wr_s && io_tx_s && tx_full_s;
    assign tx_pop_s     = !tx_empty_s && tx_ready;
    assign rx_pop_s     = rd_s && io_rx_s && !rx_empty_s;
    assign rx_unf_set_s = rd_s && io_rx_s && rx_empty_s;
    assign rx_push_s    = rx_valid && !rx_full_s;
    assign tx_ovf_clr_s = wr_s && io_st_s && databus[4];
    assign rx_unf_clr_s = wr_s && io_st_s && databus[5];
    assign ram_we_s     = wr_s && ram_hit_s;

    assign status_s = {2'b00, rx_unf_r, tx_ovf_r, rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};

    // Stream outputs come from registered FIFO state only.
    assign tx_valid = !tx_empty_s;
    assign tx_data  = tx_empty_s ? 8'h00 : tx_mem_r[tx_rptr_r];
    assign rx_ready = !rx_full_s;

    // Read data mux for the current access.
    always_comb begin
        rdata_s = 8'h00;
        if (ram_hit_s) begin
            rdata_s = ram_mem_r[addrbus[RAM_AW-1:0]];
        end else if (io_rx_s) begin
            rdata_s = rx_empty_s ? 8'h00 : rx_mem_r[rx_rptr_r];
        end else if (io_st_s) begin
            rdata_s = status_s;
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign drive_s = !rst && rd_s && (ram_hit_s || io_hit_s);
    assign databus = drive_s ? rdata_s : 8'bzzzz_zzzz;

    // RAM write port; a write on an edge coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && ram_we_s) begin
            ram_mem_r[addrbus[RAM_AW-1:0]] <= databus;
        end
    end

    // FIFO data slots.
    always_ff @(posedge clk) begin
        if (!rst && tx_push_s) begin
            tx_mem_r[tx_wptr_r] <= databus;
        end
        if (!rst && rx_push_s) begin
            rx_mem_r[rx_wptr_r] <= rx_data;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_r <= PTR_ZERO;
            tx_rptr_r <= PTR_ZERO;
            tx_cnt_r  <= CNT_ZERO;
        end else begin
            if (tx_push_s) begin
                tx_wptr_r <= tx_wptr_r + PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rptr_r <= tx_rptr_r + PTR_ONE;
            end
            tx_cnt_r <= cnt_next(tx_cnt_r, tx_push_s, tx_pop_s);
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr_r <= PTR_ZERO;
            rx_rptr_r <= PTR_ZERO;
            rx_cnt_r  <= CNT_ZERO;
        end else begin
            if (rx_push_s) begin
                rx_wptr_r <= rx_wptr_r + PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rptr_r <= rx_rptr_r + PTR_ONE;
            end
            rx_cnt_r <= cnt_next(rx_cnt_r, rx_push_s, rx_pop_s);
        end
    end

    // Sticky error flags; a clear request beats a set on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_r <= 1'b0;
            rx_unf_r <= 1'b0;
        end else begin
            if (tx_ovf_clr_s) begin
                tx_ovf_r <= 1'b0;
            end else if (tx_ovf_set_s) begin
                tx_ovf_r <= 1'b1;
            end else begin
                tx_ovf_r <= tx_ovf_r;
            end
            if (rx_unf_clr_s) begin
                rx_unf_r <= 1'b0;
            end else if (rx_unf_set_s) begin
                rx_unf_r <= 1'b1;
            end else begin
                rx_unf_r <= rx_unf_r;
            end
        end
    end

endmodule

// File: tb/tb_javk_memio.sv
// Self-checking bench for javk_memio: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based model of the bus responder. A released databus reads 8'hFF
// through the bench's pull-ups.

module tb_javk_memio;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] addr     = 16'hFF02;
    logic        rw       = 1'b1;
    logic [7:0]  wdata    = 8'h00;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    wire  [7:0]  databus;
    wire  [7:0]  tx_data;
    wire         tx_valid;
    wire         rx_ready;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [7:0] ram_m [0:255];
    bit         ram_k [0:255];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         ovf_m = 1'b0;
    bit         unf_m = 1'b0;

    javk_memio dut (
        .clk      (clk),
        .rst      (rst),
        .databus  (databus),
        .addrbus  (addr),
        .rw       (rw),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    assign databus = rw ? 8'bzzzz_zzzz : wdata;
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (databus[g]);
    end

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ram(input logic [15:0] a);
        return a < 16'h0100;
    endfunction

    function automatic bit is_io(input logic [15:0] a);
        return a == 16'hFF00 || a == 16'hFF01 || a == 16'hFF02;
    endfunction

    // Model update on every edge, from pre-edge model state.
    always @(posedge clk or posedge rst) begin
        bit tx_full_pre, rx_full_pre, rx_empty_pre, push_tx;
        if (rst) begin
            txq.delete();
            rxq.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            tx_full_pre  = (txq.size() == 4);
            rx_full_pre  = (rxq.size() == 4);
            rx_empty_pre = (rxq.size() == 0);
            push_tx      = 1'b0;
            if (!rw && addr == 16'hFF00) begin
                if (tx_full_pre) ovf_m = 1'b1;
                else push_tx = 1'b1;
            end
            if (tx_ready && txq.size() != 0) void'(txq.pop_front());
            if (push_tx) txq.push_back(wdata);
            if (rw && addr == 16'hFF01) begin
                if (rx_empty_pre) unf_m = 1'b1;
                else void'(rxq.pop_front());
            end
            if (rx_valid && !rx_full_pre) rxq.push_back(rx_data);
            if (!rw && addr == 16'hFF02) begin
                if (wdata[4]) ovf_m = 1'b0;
                if (wdata[5]) unf_m = 1'b0;
            end
            if (!rw && is_ram(addr)) begin
                ram_m[addr[7:0]] = wdata;
                ram_k[addr[7:0]] = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        logic [7:0] st;
        if (chk_en) begin
            check8("tx_valid", tx_valid, txq.size() != 0);
            if (txq.size() != 0) check8("tx_data", tx_data, txq[0]);
            check8("rx_ready", rx_ready, rxq.size() < 4);
            if (rw) begin
                st = {2'b00, unf_m, ovf_m, rxq.size() == 4, rxq.size() == 0,
                      txq.size() == 0, txq.size() == 4};
                if (rst || !(is_ram(addr) || is_io(addr))) check8("bus_release", databus, 8'hFF);
                else if (is_ram(addr)) begin
                    if (ram_k[addr[7:0]]) check8("ram_read", databus, ram_m[addr[7:0]]);
                end
                else if (addr == 16'hFF00) check8("txdata_read", databus, 8'h00);
                else if (addr == 16'hFF01) check8("rxdata_read", databus, rxq.size() != 0 ? rxq[0] : 8'h00);
                else check8("status_read", databus, st);
            end
        end
    end

    // One bus access: present it, sample databus mid-cycle, finish after the edge.
    task automatic acc(input logic [15:0] a, input logic r, input logic [7:0] d, output logic [7:0] q);
        addr  = a;
        rw    = r;
        wdata = d;
        @(negedge clk);
        q = databus;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q;
        int sel;

        // Reset state
        #12;
        check8("rst_tx_valid", tx_valid, 1'b0);
        check8("rst_tx_data", tx_data, 8'h00);
        check8("rst_rx_ready", rx_ready, 1'b1);
        check8("rst_bus_release", databus, 8'hFF);
        #10;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        acc(16'hFF02, 1'b1, 8'h00, q); check8("status_after_reset", q, 8'h06);
        acc(16'h8000, 1'b1, 8'h00, q); check8("unmapped_read", q, 8'hFF);

        // RAM
        acc(16'h0000, 1'b0, 8'h3C, q);
        acc(16'h0010, 1'b0, 8'hA5, q);
        acc(16'h00FF, 1'b0, 8'h5A, q);
        acc(16'h0010, 1'b1, 8'h00, q); check8("ram_0010", q, 8'hA5);
        acc(16'h00FF, 1'b1, 8'h00, q); check8("ram_00ff", q, 8'h5A);
        acc(16'h0100, 1'b0, 8'h11, q);
        acc(16'h0000, 1'b1, 8'h00, q); check8("ram_no_alias", q, 8'h3C);

        // TX overflow then drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) acc(16'hFF00, 1'b0, 8'(i), q);
        acc(16'hFF02, 1'b1, 8'h00, q); check8("status_tx_full_ovf", q, 8'h15);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check8("host_tx_valid", tx_valid, 1'b1);
            check8("host_tx_byte", tx_data, 8'(i));
            acc(16'h8000, 1'b1, 8'h00, q);
        end
        check8("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;
        acc(16'hFF02, 1'b0, 8'h10, q);

        // RX fill, drain, underflow
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'hC1 + 8'(i);
            acc(16'h8000, 1'b1, 8'h00, q);
        end
        rx_valid = 1'b0;
        check8("rx_full_ready", rx_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            acc(16'hFF01, 1'b1, 8'h00, q); check8("rx_read", q, 8'hC1 + 8'(i));
        end
        acc(16'hFF01, 1'b1, 8'h00, q); check8("rx_underflow_read", q, 8'h00);
        acc(16'hFF02, 1'b1, 8'h00, q); check8("status_rx_unf", q, 8'h26);
        acc(16'hFF02, 1'b0, 8'h20, q);
        acc(16'hFF02, 1'b1, 8'h00, q); check8("status_unf_cleared", q, 8'h06);

        // RX full with simultaneous host offer and CPU pop
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'hD1 + 8'(i);
            acc(16'h8000, 1'b1, 8'h00, q);
        end
        rx_data = 8'hC5;
        check8("rx_full_hold", rx_ready, 1'b0);
        acc(16'hFF01, 1'b1, 8'h00, q); check8("rx_pop_when_full", q, 8'hD1);
        check8("rx_room_after_pop", rx_ready, 1'b1);
        acc(16'h8000, 1'b1, 8'h00, q);
        rx_valid = 1'b0;
        check8("rx_refilled", rx_ready, 1'b0);
        acc(16'hFF01, 1'b1, 8'h00, q); check8("rx_wrap_0", q, 8'hD2);
        acc(16'hFF01, 1'b1, 8'h00, q); check8("rx_wrap_1", q, 8'hD3);
        acc(16'hFF01, 1'b1, 8'h00, q); check8("rx_wrap_2", q, 8'hD4);
        acc(16'hFF01, 1'b1, 8'h00, q); check8("rx_wrap_3", q, 8'hC5);

        // Asynchronous reset mid-cycle with TX partly full
        for (int i = 0; i < 3; i++) acc(16'hFF00, 1'b0, 8'h71 + 8'(i), q);
        check8("tx_before_rst", tx_valid, 1'b1);
        addr = 16'hFF02;
        rw   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check8("async_rst_tx_valid", tx_valid, 1'b0);
        check8("async_rst_tx_data", tx_data, 8'h00);
        check8("async_rst_rx_ready", rx_ready, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        acc(16'hFF02, 1'b1, 8'h00, q); check8("status_after_async_rst", q, 8'h06);
        acc(16'h0010, 1'b1, 8'h00, q); check8("ram_kept_0010", q, 8'hA5);
        acc(16'h00FF, 1'b1, 8'h00, q); check8("ram_kept_00ff", q, 8'h5A);

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 2000; n++) begin
            tx_ready = ($urandom_range(3) != 0);
            rx_valid = ($urandom_range(2) != 0);
            rx_data  = 8'($urandom);
            sel = $urandom_range(9);
            case (sel)
                0, 1, 2: addr = {8'h00, 8'($urandom)};
                3, 4:    addr = 16'hFF00;
                5, 6:    addr = 16'hFF01;
                7:       addr = 16'hFF02;
                default: addr = 16'($urandom_range(16'hFEFF, 16'h0100));
            endcase
            acc(addr, 1'($urandom), 8'($urandom), q);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
